// File: rtl/p_shfrot_pipe.sv
// Packed shift/rotate unit plus its pipelined wrapper. The wrapper has one operand
// stage, a 2-entry result FIFO and valid/ready flow control with a synchronous flush.

module p_shfrot (
  input  logic [31:0] crs1,
  input  logic [4:0]  shamt,
  input  logic [4:0]  pw,
  input  logic        shift,
  input  logic        rotate,
  input  logic        left,
  input  logic        right,
  output logic [31:0] result
);

  // Applies one operation to every w-bit lane of src. The lane loop has a fixed
  // bound so that it unrolls; lanes beyond 32/w are skipped.
  function automatic logic [31:0] packed_op(
    input logic [31:0] src,
    input int          w,
    input logic [4:0]  sh,
    input logic        rot,
    input logic        rgt
  );
    logic [31:0] mask;
    logic [31:0] e;
    logic [31:0] r;
    logic [31:0] acc;
    int          shi;
    int          s;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    shi  = {27'd0, sh};
    s    = shi % w;
    acc  = '0;
    for (int l = 0; l < 16; l++) begin
      if (l * w < 32) begin
        e = (src >> (l * w)) & mask;
        if (rot) begin
          r = rgt ? ((e >> s) | (e << (w - s))) : ((e << s) | (e >> (w - s)));
        end else if (shi >= w) begin
          r = '0;
        end else begin
          r = rgt ? (e >> shi) : (e << shi);
        end
        acc = acc | ((r & mask) << (l * w));
      end
    end
    return acc;
  endfunction

  logic op_ok;
  logic dir_ok;

  assign op_ok  = shift ^ rotate;
  assign dir_ok = left ^ right;

  always_comb begin
    result = '0;
    if (op_ok && dir_ok) begin
      if (pw[0])      result = packed_op(crs1, 32, shamt, rotate, right);
      else if (pw[1]) result = packed_op(crs1, 16, shamt, rotate, right);
      else if (pw[2]) result = packed_op(crs1, 8,  shamt, rotate, right);
      else if (pw[3]) result = packed_op(crs1, 4,  shamt, rotate, right);
      else if (pw[4]) result = packed_op(crs1, 2,  shamt, rotate, right);
    end
  end

endmodule

module p_shfrot_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [2:0]       in_pw,
  input  logic [31:0]      in_crs1,
  input  logic [4:0]       in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  logic [4:0] pw_onehot;
  logic       pw_illegal;

  always_comb begin
    pw_onehot  = '0;
    pw_illegal = 1'b0;
    case (in_pw)
      3'd0:    pw_onehot = 5'b00001;
      3'd1:    pw_onehot = 5'b00010;
      3'd2:    pw_onehot = 5'b00100;
      3'd3:    pw_onehot = 5'b01000;
      3'd4:    pw_onehot = 5'b10000;
      default: pw_illegal = 1'b1;
    endcase
  end

  logic             s1_valid;
  logic [4:0]       s1_pw;
  logic             s1_shift;
  logic             s1_rotate;
  logic             s1_left;
  logic             s1_right;
  logic [31:0]      s1_crs1;
  logic [4:0]       s1_shamt;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_illegal;
  logic [31:0]      s1_result;

  logic [31:0]      fifo_result [2];
  logic [TAG_W-1:0] fifo_tag [2];
  logic             fifo_illegal [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_count;

  logic fifo_space;
  logic accept;
  logic s1_adv;
  logic push;
  logic pop;

  // in_ready looks only at registered state and flush, never at out_ready.
  assign fifo_space = (fifo_count < 2'd2);
  assign in_ready   = !flush && (!s1_valid || fifo_space);
  assign accept     = in_valid && in_ready;
  assign s1_adv     = s1_valid && fifo_space;
  assign push       = s1_adv && !flush;
  assign out_valid  = (fifo_count != 2'd0) && !flush;
  assign pop        = out_valid && out_ready;
  assign busy       = s1_valid || (fifo_count != 2'd0);

  p_shfrot u_shfrot (
    .crs1   (s1_crs1),
    .shamt  (s1_shamt),
    .pw     (s1_pw),
    .shift  (s1_shift),
    .rotate (s1_rotate),
    .left   (s1_left),
    .right  (s1_right),
    .result (s1_result)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      s1_valid   <= 1'b0;
      s1_pw      <= '0;
      s1_shift   <= 1'b0;
      s1_rotate  <= 1'b0;
      s1_left    <= 1'b0;
      s1_right   <= 1'b0;
      s1_crs1    <= '0;
      s1_shamt   <= '0;
      s1_tag     <= '0;
      s1_illegal <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_pw      <= pw_onehot;
        s1_shift   <= !in_op[1];
        s1_rotate  <= in_op[1];
        s1_left    <= !in_op[0];
        s1_right   <= in_op[0];
        s1_crs1    <= in_crs1;
        s1_shamt   <= in_shamt;
        s1_tag     <= in_tag;
        s1_illegal <= pw_illegal;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_result[i]  <= '0;
        fifo_tag[i]     <= '0;
        fifo_illegal[i] <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_result[wr_ptr]  <= s1_result;
        fifo_tag[wr_ptr]     <= s1_tag;
        fifo_illegal[wr_ptr] <= s1_illegal;
        wr_ptr               <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    out_result  = '0;
    out_tag     = '0;
    out_illegal = 1'b0;
    if (fifo_count != 2'd0) begin
      out_result  = fifo_result[rd_ptr];
      out_tag     = fifo_tag[rd_ptr];
      out_illegal = fifo_illegal[rd_ptr];
    end
  end

endmodule

// File: tb/tb_p_shfrot_pipe.sv
// Directed bench for p_shfrot_pipe: hand-computed vectors checked with immediate
// assertions right after each rising edge.

module tb_p_shfrot_pipe;

  localparam int TAG_W = 4;

  logic             g_clk;
  logic             g_resetn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [2:0]       in_pw;
  logic [31:0]      in_crs1;
  logic [4:0]       in_shamt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  p_shfrot_pipe #(.TAG_W(TAG_W)) dut (
    .g_clk       (g_clk),
    .g_resetn    (g_resetn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_pw       (in_pw),
    .in_crs1     (in_crs1),
    .in_shamt    (in_shamt),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input logic [2:0] pw, input logic [31:0] crs1,
                       input logic [4:0] shamt, input logic [3:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_pw    = pw;
    in_crs1  = crs1;
    in_shamt = shamt;
    in_tag   = tag;
  endtask

  // One operation alone through the pipe with out_ready high.
  task automatic run_one(input string name, input logic [1:0] op, input logic [2:0] pw,
                         input logic [31:0] crs1, input logic [4:0] shamt, input logic [3:0] tag,
                         input logic [31:0] exp, input logic exp_ill);
    out_ready = 1'b1;
    offer(op, pw, crs1, shamt, tag);
    tick();
    in_valid = 1'b0;
    tick();
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_result"}, out_result, exp);
    chk({name, "_tag"}, {28'd0, out_tag}, {28'd0, tag});
    chk({name, "_illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
    tick();
  endtask

  initial begin
    g_resetn  = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_pw     = '0;
    in_crs1   = '0;
    in_shamt  = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    g_resetn = 1'b1;
    tick();

    // Reset mid-stream with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      offer(2'b00, 3'd0, 32'hFFFF_FFFF, 5'd0, 4'(i + 1));
      tick();
    end
    in_valid = 1'b0;
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    chk("mid_in_ready_full", {31'd0, in_ready}, 32'd0);
    #2;
    g_resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_result", out_result, 32'd0);
    tick();
    g_resetn  = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // 32-bit shift right with explicit latency checks.
    out_ready = 1'b1;
    offer(2'b01, 3'd0, 32'h8000_0001, 5'd4, 4'd3);
    #1;
    chk("srl32_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("srl32_not_yet_valid", {31'd0, out_valid}, 32'd0);
    chk("srl32_busy_s1", {31'd0, busy}, 32'd1);
    tick();
    chk("srl32_valid", {31'd0, out_valid}, 32'd1);
    chk("srl32_result", out_result, 32'h0800_0000);
    chk("srl32_tag", {28'd0, out_tag}, 32'd3);
    tick();
    chk("srl32_drained", {31'd0, out_valid}, 32'd0);
    chk("srl32_idle", {31'd0, busy}, 32'd0);

    // Byte rotate left, then 2-bit rotate right, back to back.
    offer(2'b10, 3'd2, 32'h1234_5678, 5'd4, 4'd5);
    tick();
    offer(2'b11, 3'd4, 32'h0000_0001, 5'd1, 4'd6);
    tick();
    in_valid = 1'b0;
    chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_first_result", out_result, 32'h2143_6587);
    chk("b2b_first_tag", {28'd0, out_tag}, 32'd5);
    tick();
    chk("b2b_second_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_second_result", out_result, 32'h0000_0002);
    chk("b2b_second_tag", {28'd0, out_tag}, 32'd6);
    tick();
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Lane boundaries and illegal width.
    run_one("sll4_over", 2'b00, 3'd3, 32'hFFFF_FFFF, 5'd4, 4'd7, 32'h0000_0000, 1'b0);
    run_one("rol4_mod", 2'b10, 3'd3, 32'h1234_5678, 5'd5, 4'd8, 32'h2468_ACE1, 1'b0);
    run_one("srl16", 2'b01, 3'd1, 32'h8001_8000, 5'd15, 4'd2, 32'h0001_0001, 1'b0);
    run_one("ror32_0", 2'b11, 3'd0, 32'hDEAD_BEEF, 5'd0, 4'd1, 32'hDEAD_BEEF, 1'b0);
    run_one("illegal_pw6", 2'b00, 3'd6, 32'hFFFF_FFFF, 5'd3, 4'd9, 32'h0000_0000, 1'b1);

    // Backpressure: three held, fourth refused until a slot frees.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(2'b00, 3'd0, 32'd1, 5'(i), 4'(i));
      tick();
    end
    offer(2'b00, 3'd0, 32'd1, 5'd3, 4'd3);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_still_low", {31'd0, in_ready}, 32'd0);
    chk("bp_head_tag0", {28'd0, out_tag}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_no_comb_path", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_tag1", {28'd0, out_tag}, 32'd1);
    chk("bp_res1", out_result, 32'd2);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_tag2_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_tag2", {28'd0, out_tag}, 32'd2);
    chk("bp_res2", out_result, 32'd4);
    tick();
    chk("bp_tag3_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_tag3", {28'd0, out_tag}, 32'd3);
    chk("bp_res3", out_result, 32'd8);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_idle", {31'd0, busy}, 32'd0);

    // Flush with three held and a fourth offered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(2'b00, 3'd0, 32'd1, 5'd1, 4'(10 + i));
      tick();
    end
    offer(2'b00, 3'd0, 32'd1, 5'd1, 4'd13);
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_busy", {31'd0, busy}, 32'd0);
    chk("fl_result_zero", out_result, 32'd0);
    tick();
    tick();
    chk("fl_not_accepted", {31'd0, out_valid}, 32'd0);
    chk("fl_still_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
